// File: rtl/brush_stamp_writer.sv
// brush_stamp_writer: turns the cursor position into a square brush
// of material pixels. It writes one pixel per cycle and clips at the screen edges.
module brush_stamp_writer #(
  parameter int COLUMNS    = 640,
  parameter int ROWS       = 400,
  parameter int ADDR_WIDTH = $clog2(COLUMNS*ROWS),
  parameter int DATA_WIDTH = 2,
  parameter int BRUSH_SIZE = 4,
  localparam int XW = $clog2(COLUMNS),
  localparam int YW = $clog2(ROWS)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  draw_en_i,
  input  logic [XW-1:0]         mouse_x_position_i,
  input  logic [YW-1:0]         mouse_y_position_i,
  input  logic [DATA_WIDTH-1:0] material_i,
  output logic [ADDR_WIDTH-1:0] ram_wr_address_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic                  ram_wr_en_o,
  output logic                  busy_o,
  output logic                  stamp_done_o
);

  // 5 bits hold any offset 0..15 of a brush up to 16 wide
  localparam int CW  = 5;
  localparam int PXW = XW + CW;
  localparam int PYW = YW + CW;
  localparam int MW  = PYW + XW + PXW;
  localparam logic [CW-1:0] BM1 = CW'(BRUSH_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [XW-1:0]         r_base_x;
  logic [YW-1:0]         r_base_y;
  logic [DATA_WIDTH-1:0] r_mat;
  logic [CW-1:0]         r_dx;
  logic [CW-1:0]         r_dy;
  logic [XW-1:0]         r_last_x;
  logic [YW-1:0]         r_last_y;
  logic [DATA_WIDTH-1:0] r_last_mat;
  logic                  r_last_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_en;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_dup;
  logic                  w_start;
  logic                  w_last_pix;
  logic [XW-1:0]         w_src_x;
  logic [YW-1:0]         w_src_y;
  logic [CW-1:0]         w_nx;
  logic [CW-1:0]         w_ny;
  logic [PXW-1:0]        w_px;
  logic [PYW-1:0]        w_py;
  logic [MW-1:0]         w_addr_full;
  logic                  w_in;

  // Next pixel: (0,0) of the live cursor when idle, else the next brush offset
  always_comb begin
    w_dup = r_last_valid
         && (mouse_x_position_i == r_last_x)
         && (mouse_y_position_i == r_last_y)
         && (material_i == r_last_mat);
    w_start    = (r_state == S_IDLE) && draw_en_i && !w_dup;
    w_last_pix = (r_dx == BM1) && (r_dy == BM1);
    w_src_x    = r_base_x;
    w_src_y    = r_base_y;
    w_nx       = '0;
    w_ny       = '0;
    if (r_state == S_IDLE) begin
      w_src_x = mouse_x_position_i;
      w_src_y = mouse_y_position_i;
    end else if (r_dx == BM1) begin
      w_ny = r_dy + CW'(1);
    end else begin
      w_nx = r_dx + CW'(1);
      w_ny = r_dy;
    end
    w_px = {{CW{1'b0}}, w_src_x} + {{XW{1'b0}}, w_nx};
    w_py = {{CW{1'b0}}, w_src_y} + {{YW{1'b0}}, w_ny};
    w_addr_full = MW'(w_py) * MW'(COLUMNS) + MW'(w_px);
    w_in = (w_px < PXW'(COLUMNS)) && (w_py < PYW'(ROWS));
  end

  // Stamp sequencer with registered write port and status outputs
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state      <= S_IDLE;
      r_base_x     <= '0;
      r_base_y     <= '0;
      r_mat        <= '0;
      r_dx         <= '0;
      r_dy         <= '0;
      r_last_x     <= '0;
      r_last_y     <= '0;
      r_last_mat   <= '0;
      r_last_valid <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_en         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_en   <= 1'b0;
          r_done <= 1'b0;
          if (w_start) begin
            r_state  <= S_WRITE;
            r_base_x <= mouse_x_position_i;
            r_base_y <= mouse_y_position_i;
            r_mat    <= material_i;
            r_dx     <= '0;
            r_dy     <= '0;
            r_busy   <= 1'b1;
            r_addr   <= ADDR_WIDTH'(w_addr_full);
            r_data   <= material_i;
            r_en     <= w_in;
          end
        end
        S_WRITE: begin
          if (w_last_pix) begin
            r_state      <= S_DONE;
            r_en         <= 1'b0;
            r_done       <= 1'b1;
            r_last_x     <= r_base_x;
            r_last_y     <= r_base_y;
            r_last_mat   <= r_mat;
            r_last_valid <= 1'b1;
          end else begin
            r_dx   <= w_nx;
            r_dy   <= w_ny;
            r_addr <= ADDR_WIDTH'(w_addr_full);
            r_data <= r_mat;
            r_en   <= w_in;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_dx    <= '0;
          r_dy    <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ram_wr_address_o = r_addr;
  assign ram_wr_data_o    = r_data;
  assign ram_wr_en_o      = r_en;
  assign busy_o           = r_busy;
  assign stamp_done_o     = r_done;

endmodule

// File: tb/tb_brush_stamp_writer.sv
// tb_brush_stamp_writer: directed checks of brush_stamp_writer
// with default 640x400 screen and a 4x4 brush.
module tb_brush_stamp_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        draw_en;
  logic [9:0]  mx;
  logic [8:0]  my;
  logic [1:0]  mat;
  logic [17:0] addr;
  logic [1:0]  data;
  logic        wen;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic        s_en   [0:127];
  logic [17:0] s_addr [0:127];
  logic [1:0]  s_data [0:127];
  logic        s_busy [0:127];
  logic        s_done [0:127];

  always #5 clk = ~clk;

  brush_stamp_writer dut (
    .clk_i              (clk),
    .reset_i            (reset_n),
    .draw_en_i          (draw_en),
    .mouse_x_position_i (mx),
    .mouse_y_position_i (my),
    .material_i         (mat),
    .ram_wr_address_o   (addr),
    .ram_wr_data_o      (data),
    .ram_wr_en_o        (wen),
    .busy_o             (busy),
    .stamp_done_o       (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input int n, input int drop_at, input int move_at,
                     input int nx, input int ny, input logic [1:0] nm);
    for (int i = 0; i < n; i++) begin
      step();
      s_en[i]   = wen;
      s_addr[i] = addr;
      s_data[i] = data;
      s_busy[i] = busy;
      s_done[i] = done;
      if (i == drop_at) draw_en = 1'b0;
      if (i == move_at) begin
        mx  = 10'(nx);
        my  = 9'(ny);
        mat = nm;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    draw_en = 1'b0;
    mx = '0;
    my = '0;
    mat = '0;
    step();
    step();
    total++;
    if (wen !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl got en=%b busy=%b done=%b exp 0 0 0",
               wen, busy, done);
    end
    total++;
    if (addr !== 18'd0 || data !== 2'd0) begin
      bad++;
      $display("FAIL reset_data got addr=%0d data=%0d exp 0 0",
               addr, data);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int ex;
    int ey;
    mx = 10'd10;
    my = 9'd20;
    mat = 2'b01;
    draw_en = 1'b1;
    cap(18, 0, -1, 0, 0, 2'b00);
    for (int k = 0; k < 16; k++) begin
      ex = 10 + k % 4;
      ey = 20 + k / 4;
      total++;
      if (s_en[k] !== 1'b1 || s_addr[k] !== 18'(ey * 640 + ex) ||
          s_data[k] !== 2'b01 || s_busy[k] !== 1'b1) begin
        bad++;
        $display("FAIL basic_pix k=%0d got en=%b addr=%0d data=%0d busy=%b exp 1 %0d 1 1",
                 k, s_en[k], s_addr[k], s_data[k], s_busy[k], ey * 640 + ex);
      end
    end
    total++;
    if (s_addr[0] !== 18'd12810 || s_addr[15] !== 18'd14733) begin
      bad++;
      $display("FAIL basic_ends got %0d %0d exp 12810 14733",
               s_addr[0], s_addr[15]);
    end
    total++;
    if (s_done[15] !== 1'b0 || s_done[16] !== 1'b1 ||
        s_en[16] !== 1'b0 || s_busy[16] !== 1'b1) begin
      bad++;
      $display("FAIL basic_done got done15=%b done16=%b en16=%b busy16=%b exp 0 1 0 1",
               s_done[15], s_done[16], s_en[16], s_busy[16]);
    end
    total++;
    if (s_busy[17] !== 1'b0 || s_done[17] !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle got busy=%b done=%b exp 0 0",
               s_busy[17], s_done[17]);
    end
  endtask

  task automatic test_right_clip();
    int cnt;
    int ex;
    int ey;
    logic ee;
    cnt = 0;
    mx = 10'd638;
    my = 9'd5;
    mat = 2'b10;
    draw_en = 1'b1;
    cap(18, 0, -1, 0, 0, 2'b00);
    for (int k = 0; k < 16; k++) begin
      ex = 638 + k % 4;
      ey = 5 + k / 4;
      ee = (ex < 640);
      if (s_en[k] === 1'b1) cnt++;
      total++;
      if (s_en[k] !== ee || s_addr[k] !== 18'(ey * 640 + ex) ||
          s_data[k] !== 2'b10) begin
        bad++;
        $display("FAIL right_pix k=%0d got en=%b addr=%0d data=%0d exp %b %0d 2",
                 k, s_en[k], s_addr[k], s_data[k], ee, ey * 640 + ex);
      end
    end
    total++;
    if (cnt !== 8 || s_addr[3] !== 18'd3841 || s_addr[13] !== 18'd5759) begin
      bad++;
      $display("FAIL right_count got cnt=%0d a3=%0d a13=%0d exp 8 3841 5759",
               cnt, s_addr[3], s_addr[13]);
    end
    total++;
    if (s_done[16] !== 1'b1) begin
      bad++;
      $display("FAIL right_done got %b exp 1", s_done[16]);
    end
  endtask

  task automatic test_corner_clip();
    int cnt;
    int hi;
    logic [17:0] wa;
    cnt = 0;
    hi = 0;
    wa = '0;
    mx = 10'd639;
    my = 9'd399;
    mat = 2'b11;
    draw_en = 1'b1;
    cap(18, 0, -1, 0, 0, 2'b00);
    for (int k = 0; k < 17; k++) begin
      if (s_en[k] === 1'b1) begin
        cnt++;
        wa = s_addr[k];
        if (s_addr[k] >= 18'd256000) hi++;
      end
    end
    total++;
    if (cnt !== 1 || wa !== 18'd255999) begin
      bad++;
      $display("FAIL corner_write got cnt=%0d addr=%0d exp 1 255999", cnt, wa);
    end
    total++;
    if (hi !== 0) begin
      bad++;
      $display("FAIL corner_range got %0d out-of-range writes exp 0", hi);
    end
    total++;
    if (s_done[16] !== 1'b1 || s_en[0] !== 1'b1) begin
      bad++;
      $display("FAIL corner_timing got en0=%b done16=%b exp 1 1",
               s_en[0], s_done[16]);
    end
  endtask

  task automatic test_dedup();
    int cnt;
    int dn;
    cnt = 0;
    dn = 0;
    mx = 10'd10;
    my = 9'd20;
    mat = 2'b01;
    draw_en = 1'b1;
    cap(100, -1, -1, 0, 0, 2'b00);
    for (int k = 0; k < 100; k++) begin
      if (s_en[k] === 1'b1) cnt++;
      if (s_done[k] === 1'b1) dn++;
    end
    total++;
    if (cnt !== 16 || dn !== 1) begin
      bad++;
      $display("FAIL dedup_hold got writes=%0d dones=%0d exp 16 1", cnt, dn);
    end
    mx = 10'd11;
    cnt = 0;
    cap(18, -1, -1, 0, 0, 2'b00);
    for (int k = 0; k < 18; k++) if (s_en[k] === 1'b1) cnt++;
    total++;
    if (cnt !== 16 || s_en[0] !== 1'b1 || s_addr[0] !== 18'd12811 ||
        s_data[0] !== 2'b01 || s_done[16] !== 1'b1) begin
      bad++;
      $display("FAIL dedup_move got writes=%0d en0=%b a0=%0d d0=%0d done=%b exp 16 1 12811 1 1",
               cnt, s_en[0], s_addr[0], s_data[0], s_done[16]);
    end
    mat = 2'b10;
    cnt = 0;
    cap(18, -1, -1, 0, 0, 2'b00);
    for (int k = 0; k < 18; k++) if (s_en[k] === 1'b1) cnt++;
    total++;
    if (cnt !== 16 || s_addr[0] !== 18'd12811 || s_data[0] !== 2'b10) begin
      bad++;
      $display("FAIL dedup_mat got writes=%0d a0=%0d d0=%0d exp 16 12811 2",
               cnt, s_addr[0], s_data[0]);
    end
    draw_en = 1'b0;
    step();
    step();
    draw_en = 1'b1;
    cnt = 0;
    dn = 0;
    cap(20, -1, -1, 0, 0, 2'b00);
    for (int k = 0; k < 20; k++) begin
      if (s_en[k] === 1'b1) cnt++;
      if (s_busy[k] === 1'b1) dn++;
    end
    total++;
    if (cnt !== 0 || dn !== 0) begin
      bad++;
      $display("FAIL dedup_reclick got writes=%0d busy_cycles=%0d exp 0 0",
               cnt, dn);
    end
    draw_en = 1'b0;
    step();
  endtask

  task automatic test_abort_immunity();
    int ex;
    int ey;
    int errs;
    errs = 0;
    mx = 10'd100;
    my = 9'd100;
    mat = 2'b11;
    draw_en = 1'b1;
    cap(18, 2, 2, 300, 200, 2'b01);
    for (int k = 0; k < 16; k++) begin
      ex = 100 + k % 4;
      ey = 100 + k / 4;
      if (s_en[k] !== 1'b1 || s_addr[k] !== 18'(ey * 640 + ex) ||
          s_data[k] !== 2'b11) begin
        errs++;
        $display("FAIL abort_pix k=%0d got en=%b addr=%0d data=%0d exp 1 %0d 3",
                 k, s_en[k], s_addr[k], s_data[k], ey * 640 + ex);
      end
    end
    total++;
    if (errs != 0) bad++;
    total++;
    if (s_done[16] !== 1'b1 || s_busy[17] !== 1'b0) begin
      bad++;
      $display("FAIL abort_done got done=%b busy17=%b exp 1 0",
               s_done[16], s_busy[17]);
    end
  endtask

  task automatic test_reset_mid_stamp();
    int cnt;
    cnt = 0;
    mx = 10'd50;
    my = 9'd60;
    mat = 2'b10;
    draw_en = 1'b1;
    cap(5, 0, -1, 0, 0, 2'b00);
    total++;
    if (s_busy[4] !== 1'b1 || s_en[4] !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre got busy=%b en=%b exp 1 1", s_busy[4], s_en[4]);
    end
    reset_n = 1'b0;
    step();
    total++;
    if (wen !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        addr !== 18'd0 || data !== 2'd0) begin
      bad++;
      $display("FAIL rst_mid got en=%b busy=%b done=%b addr=%0d data=%0d exp 0 0 0 0 0",
               wen, busy, done, addr, data);
    end
    reset_n = 1'b1;
    mx = 10'd100;
    my = 9'd100;
    mat = 2'b11;
    draw_en = 1'b1;
    cap(18, 0, -1, 0, 0, 2'b00);
    for (int k = 0; k < 18; k++) if (s_en[k] === 1'b1) cnt++;
    total++;
    if (cnt !== 16 || s_addr[0] !== 18'd64100 || s_done[16] !== 1'b1) begin
      bad++;
      $display("FAIL rst_restamp got writes=%0d a0=%0d done=%b exp 16 64100 1",
               cnt, s_addr[0], s_done[16]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_right_clip();
    test_corner_clip();
    test_dedup();
    test_abort_immunity();
    test_reset_mid_stamp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
